// File: rtl/led_out_pkg.sv
// Shared types and default timing constants for the LED/buzzer driver.
// Optional macro LED_OUT_EDGE_EN selects level inputs with edge detect.
package led_out_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int DIV_40HZ      = 1250000;
  localparam int ON_TICKS_DEF  = 4;
  localparam int OFF_TICKS_DEF = 4;
  localparam int PEND_MAX_DEF  = 7;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/led_out_chan.sv
// One indicator channel: flash FSM, tick counter, pending-flash counter.
// With LED_OUT_EDGE_EN, pin is a level fed through a 2-FF sync + edge detect.
module led_out_chan
  import led_out_pkg::*;
#(
  parameter int ON_TICKS  = ON_TICKS_DEF,
  parameter int OFF_TICKS = OFF_TICKS_DEF,
  parameter int PEND_MAX  = PEND_MAX_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic pin,
  output logic nlout,
  output logic busy
);

  localparam int CW = $clog2(imax(ON_TICKS, OFF_TICKS) + 1);
  localparam int PW = $clog2(PEND_MAX + 1);

  logic ev;

`ifdef LED_OUT_EDGE_EN
  logic [2:0] sr;

  // two sync stages plus one history stage for rise detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= '0;
    else        sr <= {sr[1:0], pin};
  end

  assign ev = sr[1] & ~sr[2];
`else
  assign ev = pin;
`endif

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [PW-1:0] pend, pend_n;
  logic          pend_up;

  assign pend_up = ev && (pend != PW'(PEND_MAX));

  // next state, tick count and pending count
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pend_n  = pend;
    unique case (state)
      IDLE: begin
        if (ev) begin
          state_n = ON;
          cnt_n   = '0;
        end
      end
      ON: begin
        if (pend_up) pend_n = pend + 1'b1;
        if (tick) begin
          if (cnt == CW'(ON_TICKS - 1)) begin
            state_n = GAP;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      GAP: begin
        if (pend_up) pend_n = pend + 1'b1;
        if (tick) begin
          if (cnt == CW'(OFF_TICKS - 1)) begin
            cnt_n = '0;
            if (pend != '0) begin
              state_n = ON;
              pend_n  = ev ? pend : pend - 1'b1;
            end else if (ev) begin
              state_n = ON;
              pend_n  = '0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        pend_n  = '0;
      end
    endcase
  end

  // state registers; output registered from next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      pend  <= '0;
      nlout <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      pend  <= pend_n;
      nlout <= (state_n != ON);
    end
  end

  assign busy = (state != IDLE) || (pend != '0);

endmodule

// File: rtl/led_out.sv
// Multi-channel active-low flash driver with shared 40 Hz prescaler.
// Optional macro LED_OUT_EDGE_EN: PIN treated as async level inputs.
module led_out
  import led_out_pkg::*;
#(
  parameter int NCH       = 3,
  parameter int DIV       = DIV_40HZ,
  parameter int ON_TICKS  = ON_TICKS_DEF,
  parameter int OFF_TICKS = OFF_TICKS_DEF,
  parameter int PEND_MAX  = PEND_MAX_DEF
) (
  input  logic           CLK,
  input  logic           nRST,
  input  logic [NCH-1:0] PIN,
  output logic [NCH-1:0] nLOUT,
  output logic [NCH-1:0] BUSY
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] pcnt;
  logic          tick;

  assign tick = (pcnt == PW'(DIV - 1));

  // free-running prescaler shared by all channels
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)     pcnt <= '0;
    else if (tick) pcnt <= '0;
    else           pcnt <= pcnt + 1'b1;
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    led_out_chan #(
      .ON_TICKS (ON_TICKS),
      .OFF_TICKS(OFF_TICKS),
      .PEND_MAX (PEND_MAX)
    ) u_ch (
      .clk  (CLK),
      .rst_n(nRST),
      .tick (tick),
      .pin  (PIN[i]),
      .nlout(nLOUT[i]),
      .busy (BUSY[i])
    );
  end

endmodule
